// File: rtl/breathing_sweep_counter.sv
// Bounded ramp generator for the breathing-LED PWM: sweeps out between lo..hi
// at a prescaled tick rate in triangle, saw-up, saw-down or one-shot modes.
module breathing_sweep_counter #(
  parameter int BITS          = 8,
  parameter int PRESCALE_BITS = 8,
  parameter int HOLD_TICKS    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [BITS-1:0]          lo,
  input  logic [BITS-1:0]          hi,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic [BITS-1:0]          out,
  output logic                     dir,
  output logic                     wrap,
  output logic                     done
);

  localparam int HCNT_BITS = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HCNT_BITS-1:0] HOLD_MAX = HCNT_BITS'(HOLD_TICKS);
  localparam logic [HCNT_BITS-1:0] HCNT_ONE = HCNT_BITS'(1);

  typedef enum logic [2:0] {UP, HOLD_HI, DOWN, HOLD_LO, DONE} state_t;

  state_t                   state, state_n;
  logic [BITS-1:0]          out_n;
  logic                     dir_n, wrap_n, done_n;
  logic [PRESCALE_BITS-1:0] pcnt, pcnt_n;
  logic [HCNT_BITS-1:0]     hcnt, hcnt_n;
  logic [1:0]               mode_q;
  logic                     tick;
  logic [BITS-1:0]          below_hi, above_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= UP;
      out    <= '0;
      dir    <= 1'b1;
      wrap   <= 1'b0;
      done   <= 1'b0;
      pcnt   <= '0;
      hcnt   <= '0;
      mode_q <= mode;
    end else begin
      state  <= state_n;
      out    <= out_n;
      dir    <= dir_n;
      wrap   <= wrap_n;
      done   <= done_n;
      pcnt   <= pcnt_n;
      hcnt   <= hcnt_n;
      mode_q <= mode;
    end
  end

  assign tick = enable && (pcnt == prescale);
  // Reversal targets collapse onto the single legal value when lo == hi.
  assign below_hi = (lo == hi) ? hi : hi - 1'b1;
  assign above_lo = (lo == hi) ? lo : lo + 1'b1;

  always_comb begin
    state_n = state;
    out_n   = out;
    hcnt_n  = hcnt;
    wrap_n  = 1'b0;
    done_n  = done;
    pcnt_n  = pcnt;
    if (enable) pcnt_n = tick ? '0 : pcnt + 1'b1;

    // A mode change restarts the sweep direction and swallows any tick.
    if (mode != mode_q) begin
      state_n = (mode == 2'd2) ? DOWN : UP;
      hcnt_n  = '0;
      done_n  = 1'b0;
      pcnt_n  = pcnt;
    end else if (tick && state != DONE) begin
      if (out < lo || out > hi) begin
        out_n   = (mode == 2'd2) ? hi : lo;
        state_n = (mode == 2'd2) ? DOWN : UP;
        hcnt_n  = '0;
      end else begin
        case (state)
          UP: begin
            if (out < hi) out_n = out + 1'b1;
            else if (mode == 2'd1) begin
              out_n  = lo;
              wrap_n = 1'b1;
            end else if (HOLD_TICKS > 0) begin
              state_n = HOLD_HI;
              hcnt_n  = HCNT_ONE;
            end else begin
              state_n = DOWN;
              out_n   = below_hi;
              wrap_n  = 1'b1;
            end
          end
          HOLD_HI: begin
            if (hcnt == HOLD_MAX) begin
              state_n = DOWN;
              out_n   = below_hi;
              hcnt_n  = '0;
              wrap_n  = 1'b1;
            end else hcnt_n = hcnt + 1'b1;
          end
          DOWN: begin
            if (out > lo) out_n = out - 1'b1;
            else if (mode == 2'd2) begin
              out_n  = hi;
              wrap_n = 1'b1;
            end else if (mode == 2'd3) begin
              state_n = DONE;
              done_n  = 1'b1;
              wrap_n  = 1'b1;
            end else if (HOLD_TICKS > 0) begin
              state_n = HOLD_LO;
              hcnt_n  = HCNT_ONE;
            end else begin
              state_n = UP;
              out_n   = above_lo;
              wrap_n  = 1'b1;
            end
          end
          HOLD_LO: begin
            if (hcnt == HOLD_MAX) begin
              state_n = UP;
              out_n   = above_lo;
              hcnt_n  = '0;
              wrap_n  = 1'b1;
            end else hcnt_n = hcnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dir_n = dir;
    case (state_n)
      UP, HOLD_HI:   dir_n = 1'b1;
      DOWN, HOLD_LO: dir_n = 1'b0;
      default:       dir_n = dir;
    endcase
  end

endmodule

// File: tb/tb_breathing_sweep_counter.sv
// Scoreboard bench for breathing_sweep_counter: two instances (no dwell and
// one-tick dwell) share stimulus; expected {out,dir,wrap,done} are hand-derived.
module tb_breathing_sweep_counter;

  localparam int BITS = 4;
  localparam int PB   = 4;

  // Expected words are 16'hODWN: out, dir, wrap, done, one hex digit each.
  localparam logic [15:0] T12_0 [12] = '{16'h2100, 16'h3100, 16'h4100, 16'h5100,
                                         16'h4010, 16'h3000, 16'h2000, 16'h3110,
                                         16'h4100, 16'h5100, 16'h4010, 16'h3000};
  localparam logic [15:0] T12_1 [12] = '{16'h2100, 16'h3100, 16'h4100, 16'h5100,
                                         16'h5100, 16'h4010, 16'h3000, 16'h2000,
                                         16'h2000, 16'h3110, 16'h4100, 16'h5100};
  localparam logic [15:0] T3 [26] = '{16'h0100, 16'h0100, 16'h1100, 16'h1100, 16'h1100,
                                      16'h2100, 16'h2100, 16'h2100, 16'h3100, 16'h3100,
                                      16'h3100, 16'h0110, 16'h0100, 16'h0100, 16'h1100,
                                      16'h1100, 16'h1100, 16'h1100, 16'h1100, 16'h1100,
                                      16'h1100, 16'h1100, 16'h2100, 16'h2100, 16'h2100,
                                      16'h3100};
  localparam logic [15:0] T4_0 [18] = '{16'h1100, 16'h2100, 16'h3100, 16'h2010, 16'h1000,
                                        16'h1011, 16'h1001, 16'h1001, 16'h1001, 16'h1001,
                                        16'h1001, 16'h1001, 16'h1001, 16'h1001, 16'h1001,
                                        16'h1001, 16'h1100, 16'h2100};
  localparam logic [15:0] T4_1 [18] = '{16'h1100, 16'h2100, 16'h3100, 16'h3100, 16'h2010,
                                        16'h1000, 16'h1011, 16'h1001, 16'h1001, 16'h1001,
                                        16'h1001, 16'h1001, 16'h1001, 16'h1001, 16'h1001,
                                        16'h1001, 16'h1100, 16'h2100};
  localparam logic [15:0] T5_0 [14] = '{16'h1100, 16'h2100, 16'h3100, 16'h4100, 16'h5100,
                                        16'h6100, 16'h7100, 16'h0100, 16'h1100, 16'h2100,
                                        16'h3100, 16'h4100, 16'h3010, 16'h0100};
  localparam logic [15:0] T5_1 [14] = '{16'h1100, 16'h2100, 16'h3100, 16'h4100, 16'h5100,
                                        16'h6100, 16'h7100, 16'h0100, 16'h1100, 16'h2100,
                                        16'h3100, 16'h4100, 16'h4100, 16'h0100};
  localparam logic [15:0] T6_0 [6] = '{16'h6100, 16'h6010, 16'h6110, 16'h6010, 16'h6110, 16'h6010};
  localparam logic [15:0] T6_1 [6] = '{16'h6100, 16'h6100, 16'h6010, 16'h6000, 16'h6110, 16'h6100};
  localparam logic [15:0] T7 [9] = '{16'h1100, 16'h1000, 16'h3010, 16'h2000, 16'h1000,
                                     16'h3010, 16'h5000, 16'h4000, 16'h5010};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, enable;
  logic [1:0]      mode;
  logic [BITS-1:0] lo, hi;
  logic [PB-1:0]   prescale;
  logic [BITS-1:0] out0, out1;
  logic            dir0, dir1, wrap0, wrap1, done0, done1;

  breathing_sweep_counter #(.BITS(BITS), .PRESCALE_BITS(PB), .HOLD_TICKS(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .lo(lo), .hi(hi),
    .prescale(prescale), .out(out0), .dir(dir0), .wrap(wrap0), .done(done0));

  breathing_sweep_counter #(.BITS(BITS), .PRESCALE_BITS(PB), .HOLD_TICKS(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .lo(lo), .hi(hi),
    .prescale(prescale), .out(out1), .dir(dir1), .wrap(wrap1), .done(done1));

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  md;
    logic [3:0]  l, h, p;
    logic [15:0] e0, e1;
    int          test, step;
  } vec_t;

  typedef struct {
    logic [15:0] e0, e1;
    int          test, step;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_test = 0;
  int   cur_step = 0;

  function automatic void start_test(input int t);
    cur_test = t;
    cur_step = 0;
  endfunction

  function automatic void add(input logic rst, input logic en, input logic [1:0] md,
                              input logic [3:0] l, input logic [3:0] h, input logic [3:0] p,
                              input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.rst = rst; v.en = en; v.md = md; v.l = l; v.h = h; v.p = p;
    v.e0 = e0; v.e1 = e1; v.test = cur_test; v.step = cur_step;
    vecs.push_back(v);
    cur_step++;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    reset    = v.rst;
    enable   = v.en;
    mode     = v.md;
    lo       = v.l;
    hi       = v.h;
    prescale = v.p;
    e.e0 = v.e0; e.e1 = v.e1; e.test = v.test; e.step = v.step;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_output(input int dut, input logic [3:0] o, input logic d,
                              input logic w, input logic dn, input logic [15:0] e,
                              input int t, input int s);
    logic [6:0] got, want;
    got  = {o, d, w, dn};
    want = {e[15:12], e[8], e[4], e[0]};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL test%0d step%0d dut%0d: got out=%0d dir=%b wrap=%b done=%b, expected out=%0d dir=%b wrap=%b done=%b",
               t, s, dut, o, d, w, dn, e[15:12], e[8], e[4], e[0]);
    end
  endtask

  // Monitor: the DUT presents a new registered result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output(0, out0, dir0, wrap0, done0, e.e0, e.test, e.step);
        check_output(1, out1, dir1, wrap1, done1, e.e1, e.test, e.step);
      end
    end
  end

  initial begin
    // Triangle lo=2 hi=5, with and without dwell.
    start_test(1);
    add(1, 1, 2'd0, 4'd2, 4'd5, 4'd0, 16'h0100, 16'h0100);
    for (int i = 0; i < 12; i++) add(0, 1, 2'd0, 4'd2, 4'd5, 4'd0, T12_0[i], T12_1[i]);

    // Saw-up with prescale=2 and a 5-cycle enable freeze.
    start_test(3);
    add(1, 1, 2'd1, 4'd0, 4'd3, 4'd2, 16'h0100, 16'h0100);
    for (int i = 0; i < 26; i++)
      add(0, (i >= 16 && i <= 20) ? 1'b0 : 1'b1, 2'd1, 4'd0, 4'd3, 4'd2, T3[i], T3[i]);

    // One-shot to DONE, then release by switching to triangle.
    start_test(4);
    add(1, 1, 2'd3, 4'd1, 4'd3, 4'd0, 16'h0100, 16'h0100);
    for (int i = 0; i < 18; i++)
      add(0, 1, (i >= 16) ? 2'd0 : 2'd3, 4'd1, 4'd3, 4'd0, T4_0[i], T4_1[i]);

    // Shrink hi below out, then reset while dut1 dwells at hi.
    start_test(5);
    add(1, 1, 2'd0, 4'd0, 4'd15, 4'd0, 16'h0100, 16'h0100);
    for (int i = 0; i < 14; i++)
      add((i == 13) ? 1'b1 : 1'b0, 1, 2'd0, 4'd0, (i >= 7) ? 4'd4 : 4'd15, 4'd0, T5_0[i], T5_1[i]);

    // Degenerate range lo == hi.
    start_test(6);
    add(1, 1, 2'd0, 4'd6, 4'd6, 4'd0, 16'h0100, 16'h0100);
    for (int i = 0; i < 6; i++) add(0, 1, 2'd0, 4'd6, 4'd6, 4'd0, T6_0[i], T6_1[i]);

    // Switch to saw-down, then move the window above out.
    start_test(7);
    add(1, 1, 2'd0, 4'd1, 4'd3, 4'd0, 16'h0100, 16'h0100);
    for (int i = 0; i < 9; i++)
      add(0, 1, (i >= 1) ? 2'd2 : 2'd0, (i >= 6) ? 4'd4 : 4'd1, (i >= 6) ? 4'd5 : 4'd3, 4'd0, T7[i], T7[i]);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
